// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame state and 8N1 framing constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO buffering bytes ahead of the transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 260,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CPB = 2 * CLK_PER_HALF_BIT;
  localparam int CW  = $clog2(CPB * STOP_BITS);
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n, fifo_rdata;
  logic          txd_n, pop, full, empty, bit_last, stop_last;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wvalid && wready),
    .wdata (wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  assign wready    = !full;
  assign busy      = state != IDLE || fifo_count != '0;
  assign bit_last  = cnt == CW'(CPB - 1);
  assign stop_last = cnt == CW'(CPB * STOP_BITS - 1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    sh_n    = shreg;
    txd_n   = txd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          sh_n    = fifo_rdata;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (bit_last) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
          txd_n   = shreg[0];
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_n   = '0;
          state_n = bit_idx == 3'(DATA_BITS - 1) ? STOP : DATA;
          bit_n   = bit_idx == 3'(DATA_BITS - 1) ? bit_idx : bit_idx + 3'd1;
          txd_n   = bit_idx == 3'(DATA_BITS - 1) ? 1'b1 : shreg[bit_idx + 3'd1];
        end
      end
      STOP: begin
        if (stop_last) begin
          cnt_n   = '0;
          pop     = !empty;
          state_n = empty ? IDLE : START;
          sh_n    = empty ? shreg : fifo_rdata;
          txd_n   = empty;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      txd     <= txd_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at 8 clocks per bit
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wvalid = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wready, txd, busy;
  logic [4:0] fifo_count;
  int         passed = 0;
  int         total = 0;
  logic [7:0] rx_q[$];
  int         ferr_cnt = 0;
  uart_tx #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic fbit(input logic [7:0] b, input int k);
    return (k < 8) ? 1'b0 : (k >= 72) ? 1'b1 : b[k/8-1];
  endfunction
  always begin
    logic [7:0] b;
    logic       s0, sp;
    @(negedge txd);
    repeat (4) @(posedge clk);
    #1 s0 = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1 b[i] = txd;
    end
    repeat (8) @(posedge clk);
    #1 sp = txd;
    rx_q.push_back(b);
    if (s0 !== 1'b0 || sp !== 1'b1) ferr_cnt++;
  end
  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && busy !== 1'b0; i++) tick();
    total++;
    if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    else passed++;
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) tick();
    total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b required 1", txd); else passed++;
    total++; if (wready !== 1'b1) $display("FAIL reset_wready: got %b required 1", wready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    total++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d required 0", fifo_count); else passed++;
    rstn = 1'b1;
    tick();
  endtask
  task automatic test_frame_55;
    int bad = 0;
    wdata = 8'h55; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total++; if (fifo_count !== 5'd1) $display("FAIL f55_accept_count: got %0d required 1", fifo_count); else passed++;
    for (int k = 0; k < 80; k++) begin
      tick();
      total++;
      if (txd !== fbit(8'h55, k)) $display("FAIL f55_txd cycle %0d: got %b required %b", k, txd, fbit(8'h55, k));
      else passed++;
    end
    tick();
    total++; if (busy !== 1'b0) $display("FAIL f55_busy_after: got %b required 0", busy); else passed++;
    total++; if (txd !== 1'b1) $display("FAIL f55_txd_after: got %b required 1", txd); else passed++;
  endtask
  task automatic test_back_to_back;
    wvalid = 1'b1; wdata = 8'h00;
    tick();
    wdata = 8'hFF;
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 160; k++) begin
      logic e;
      e = (k < 80) ? fbit(8'h00, k) : fbit(8'hFF, k - 80);
      total++;
      if (txd !== e) $display("FAIL b2b_txd cycle %0d: got %b required %b", k, txd, e);
      else passed++;
      tick();
    end
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy_after: got %b required 0", busy); else passed++;
  endtask
  task automatic test_fifo_full;
    logic [7:0] b [18];
    for (int i = 0; i < 18; i++) b[i] = 8'h30 + 8'(i);
    rx_q.delete();
    ferr_cnt = 0;
    wdata = b[0]; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    total++; if (fifo_count !== 5'd0) $display("FAIL full_first_pop: got %0d required 0", fifo_count); else passed++;
    wvalid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wdata = b[i];
      tick();
    end
    wdata = b[17];
    total++; if (fifo_count !== 5'd16) $display("FAIL full_count16: got %0d required 16", fifo_count); else passed++;
    total++; if (wready !== 1'b0) $display("FAIL full_wready0: got %b required 0", wready); else passed++;
    repeat (63) tick();
    total++; if (fifo_count !== 5'd16) $display("FAIL full_held_count: got %0d required 16", fifo_count); else passed++;
    total++; if (wready !== 1'b0) $display("FAIL full_held_wready: got %b required 0", wready); else passed++;
    tick();
    total++; if (fifo_count !== 5'd15) $display("FAIL full_pop_count: got %0d required 15", fifo_count); else passed++;
    total++; if (wready !== 1'b1) $display("FAIL full_pop_wready: got %b required 1", wready); else passed++;
    tick();
    wvalid = 1'b0;
    total++; if (fifo_count !== 5'd16) $display("FAIL full_17th_accept: got %0d required 16", fifo_count); else passed++;
    wait_idle("full");
    tick();
    total++;
    if (rx_q.size() !== 18) $display("FAIL full_rx_size: got %0d required 18", rx_q.size());
    else begin
      passed++;
      for (int i = 0; i < 18; i++) begin
        total++;
        if (rx_q[i] !== b[i]) $display("FAIL full_rx_byte %0d: got %02h required %02h", i, rx_q[i], b[i]);
        else passed++;
      end
    end
    total++; if (ferr_cnt !== 0) $display("FAIL full_ferr: got %0d required 0", ferr_cnt); else passed++;
  endtask
  task automatic test_reset_mid;
    logic [7:0] b [6];
    logic       seen_low = 1'b0;
    b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = b[i];
      tick();
    end
    wvalid = 1'b0;
    total++; if (fifo_count !== 5'd5) $display("FAIL rmid_buffered: got %0d required 5", fifo_count); else passed++;
    repeat (30) tick();
    total++; if (txd !== 1'b0) $display("FAIL rmid_bit3_before: got %b required 0", txd); else passed++;
    rstn = 1'b0;
    tick();
    total++; if (txd !== 1'b1) $display("FAIL rmid_txd: got %b required 1", txd); else passed++;
    total++; if (fifo_count !== 5'd0) $display("FAIL rmid_count: got %0d required 0", fifo_count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b required 0", busy); else passed++;
    rstn = 1'b1;
    tick();
    total++; if (wready !== 1'b1) $display("FAIL rmid_wready: got %b required 1", wready); else passed++;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    total++; if (seen_low !== 1'b0) $display("FAIL rmid_no_start: got %b required 0", seen_low); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy_after: got %b required 0", busy); else passed++;
    rx_q.delete();
    ferr_cnt = 0;
  endtask
  task automatic test_loopback;
    logic [7:0] e [3];
    e = '{8'h00, 8'hA5, 8'hFF};
    rx_q.delete();
    ferr_cnt = 0;
    wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = e[i];
      tick();
    end
    wvalid = 1'b0;
    wait_idle("loop");
    tick();
    total++;
    if (rx_q.size() !== 3) $display("FAIL loop_rx_size: got %0d required 3", rx_q.size());
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rx_q[i] !== e[i]) $display("FAIL loop_rx_byte %0d: got %02h required %02h", i, rx_q[i], e[i]);
        else passed++;
      end
    end
    total++; if (ferr_cnt !== 0) $display("FAIL loop_ferr: got %0d required 0", ferr_cnt); else passed++;
  endtask
  initial begin
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
